// File: rtl/modulo_arbiter.sv
// Round-robin arbiter in front of one shared iterative unsigned modulo engine.
// One request in flight at a time; the result is held until the consumer takes it.
module modulo_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [WIDTH-1:0]       resp_rem,
    output logic                   resp_dbz,
    output logic                   busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} stateT;

    stateT            state;
    stateT            nextState;
    logic [ID_W-1:0]  rrPtr;
    logic [ID_W-1:0]  nextPtr;
    logic [ID_W-1:0]  grantIdx;
    logic             grantFound;
    logic [WIDTH-1:0] grantA;
    logic [WIDTH-1:0] grantB;
    int               grantDist;
    int               bestDist;
    logic [ID_W-1:0]  opId;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] partRem;
    logic [WIDTH-1:0] shiftA;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] stepRem;

    // Winner is the valid requester with the smallest distance past the round-robin pointer.
    always_comb begin
        grantIdx  = '0;
        bestDist  = N_REQ;
        grantDist = 0;
        for (int i = 0; i < N_REQ; i++) begin
            grantDist = (i + N_REQ - int'(rrPtr)) % N_REQ;
            if (req_valid[i] && (grantDist < bestDist)) begin
                bestDist = grantDist;
                grantIdx = ID_W'(i);
            end
        end
    end

    assign grantFound = |req_valid;

    always_comb begin
        grantA = '0;
        grantB = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grantIdx == ID_W'(i)) begin
                grantA = req_a[i*WIDTH +: WIDTH];
                grantB = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // One restoring step; a borrow out of the WIDTH+1 bit difference means trial < divisor.
    always_comb begin
        trial   = {partRem, shiftA[WIDTH-1]};
        diff    = trial - {1'b0, divisor};
        stepRem = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    end

    assign nextPtr = (resp_id == ID_W'(N_REQ - 1)) ? '0 : resp_id + ID_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (grantFound) nextState = (grantB == '0) ? DONE : CALC;
            CALC: if (count == CNT_W'(1)) nextState = DONE;
            DONE: if (resp_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = (state == IDLE) && req_valid[i] && (grantIdx == ID_W'(i));
        end
        resp_valid = (state == DONE);
        busy       = (state != IDLE);
    end

    // Response fields are only loaded on entry to DONE so they hold their last values elsewhere.
    always_ff @(posedge clock) begin
        if (reset) begin
            rrPtr    <= '0;
            opId     <= '0;
            divisor  <= '0;
            partRem  <= '0;
            shiftA   <= '0;
            count    <= '0;
            resp_id  <= '0;
            resp_rem <= '0;
            resp_dbz <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantFound) begin
                        opId    <= grantIdx;
                        divisor <= grantB;
                        shiftA  <= grantA;
                        partRem <= '0;
                        count   <= CNT_W'(WIDTH);
                        if (grantB == '0) begin
                            resp_id  <= grantIdx;
                            resp_rem <= grantA;
                            resp_dbz <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    partRem <= stepRem;
                    shiftA  <= {shiftA[WIDTH-2:0], 1'b0};
                    count   <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        resp_id  <= opId;
                        resp_rem <= stepRem;
                        resp_dbz <= 1'b0;
                    end
                end
                DONE: begin
                    if (resp_ready) rrPtr <= nextPtr;
                end
                default: ;
            endcase
        end
    end

endmodule
